seq_shift_unit: RTL and testbench

//  Multi-cycle shift/rotate engine for the ALU datapath: one bit position per clock.

---
 rtl/seq_shift_unit_pkg.sv | 29 ++
 rtl/seq_shift_unit_if.sv | 27 ++
 rtl/seq_shift_unit_shift_step.sv | 24 ++
 rtl/seq_shift_unit.sv | 103 ++++++++++
 tb/tb_seq_shift_unit.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_shift_unit_pkg.sv
// Shared opcode, state and helper definitions for the sequential shift unit.
package seq_shift_unit_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_SHL  = 4'b0000;
  localparam logic [OP_W-1:0] OP_SHLA = 4'b0001;
  localparam logic [OP_W-1:0] OP_SHR  = 4'b0010;
  localparam logic [OP_W-1:0] OP_SAR  = 4'b0011;
  localparam logic [OP_W-1:0] OP_ROL  = 4'b0100;
  localparam logic [OP_W-1:0] OP_ROR  = 4'b0101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Opcodes that actually shift; everything else returns zero without stepping.
  function automatic logic op_supported(input logic [OP_W-1:0] op);
    logic ok;
    case (op)
      OP_SHL, OP_SHLA, OP_SHR, OP_SAR, OP_ROL, OP_ROR: ok = 1'b1;
      default:                                         ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/seq_shift_unit_if.sv
// Job and result handshake bundle for the sequential shift unit.
interface seq_shift_unit_if #(
  parameter int unsigned WIDTH = 4
);
  import seq_shift_unit_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [OP_W-1:0]  opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] shift_out;
  logic             busy;

  modport master (
    output in_valid, a_in, b_in, opcode, out_ready,
    input  in_ready, out_valid, shift_out, busy
  );

  modport slave (
    input  in_valid, a_in, b_in, opcode, out_ready,
    output in_ready, out_valid, shift_out, busy
  );

endinterface

// File: rtl/seq_shift_unit_shift_step.sv
// Combinational single-position step for one opcode; the top iterates it once per clock.
module seq_shift_unit_shift_step
  import seq_shift_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] data,
  input  logic [OP_W-1:0]  opcode,
  output logic [WIDTH-1:0] next_data_c
);

  always_comb begin
    next_data_c = '0;
    case (opcode)
      OP_SHL, OP_SHLA: next_data_c = {data[WIDTH-2:0], 1'b0};
      OP_SHR:          next_data_c = {1'b0, data[WIDTH-1:1]};
      OP_SAR:          next_data_c = {data[WIDTH-1], data[WIDTH-1:1]};
      OP_ROL:          next_data_c = {data[WIDTH-2:0], data[WIDTH-1]};
      OP_ROR:          next_data_c = {data[0], data[WIDTH-1:1]};
      default:         next_data_c = '0;
    endcase
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate engine: accepts a job, shifts one position per clock,
// and holds the result on a valid/ready handshake until the consumer takes it.
module seq_shift_unit
  import seq_shift_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned AMT_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  seq_shift_unit_if.slave bus
);

  state_t           state;
  logic [WIDTH-1:0] data;
  logic [OP_W-1:0]  op_q;
  logic [AMT_W-1:0] cnt;
  logic [WIDTH-1:0] next_data_c;
  logic [AMT_W-1:0] amt_c;

  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] shift_out_q;
  logic             busy_q;

  // Only the low AMT_W bits of a_in carry the amount.
  logic unused_a_hi;
  assign unused_a_hi = ^bus.a_in[WIDTH-1:AMT_W];
  assign amt_c       = bus.a_in[AMT_W-1:0];

  seq_shift_unit_shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .data        (data),
    .opcode      (op_q),
    .next_data_c (next_data_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      data        <= '0;
      op_q        <= '0;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      shift_out_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            op_q       <= bus.opcode;
            cnt        <= amt_c;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (!op_supported(bus.opcode)) begin
              data  <= '0;
              state <= ST_DONE;
            end else if (amt_c == '0) begin
              data  <= bus.b_in;
              state <= ST_DONE;
            end else begin
              data  <= bus.b_in;
              state <= ST_SHIFT;
            end
          end
        end

        ST_SHIFT: begin
          data <= next_data_c;
          cnt  <= cnt - AMT_W'(1);
          if (cnt == AMT_W'(1)) begin
            state <= ST_DONE;
          end
        end

        // First DONE cycle publishes the result; it is then held until taken.
        ST_DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            shift_out_q <= data;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state       <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.shift_out = shift_out_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Scoreboard bench for seq_shift_unit: driver pushes model results, monitor pops on out_valid.
`timescale 1ns/1ps
module tb_seq_shift_unit;
  import seq_shift_unit_pkg::*;

  typedef struct {
    logic [3:0] res;
    int         acc;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   rdy_mode = 1;
  exp_t exp_q[$];

  seq_shift_unit_if #(.WIDTH(4)) bus ();

  seq_shift_unit #(
    .WIDTH (4),
    .AMT_W (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: whole-amount shift with plain arithmetic, not step by step.
  function automatic logic [3:0] ref_shift(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    int         amt;
    logic [7:0] dbl;
    logic [3:0] r;
    amt = int'(a[1:0]);
    dbl = {b, b};
    case (op)
      4'd0, 4'd1: r = 4'(b << amt);
      4'd2:       r = b >> amt;
      4'd3:       r = 4'($signed(b) >>> amt);
      4'd4: begin dbl = dbl << amt; r = dbl[7:4]; end
      4'd5: begin dbl = dbl >> amt; r = dbl[3:0]; end
      default:    r = 4'd0;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [3:0] a, input logic [3:0] op);
    int amt;
    amt = int'(a[1:0]);
    return (op <= 4'd5 && amt != 0) ? amt + 1 : 1;
  endfunction

  task automatic do_job(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op, output int acc);
    int   waited;
    exp_t e;
    waited = 0;
    acc    = -1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a_in     = a;
    bus.b_in     = b;
    bus.opcode   = op;
    while (!bus.in_ready && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
    end else begin
      e.res = ref_shift(a, b, op);
      e.acc = cyc + 1;
      e.lat = ref_lat(a, op);
      exp_q.push_back(e);
      acc = cyc + 1;
      @(posedge clk);
      #1;
      // Scramble inputs after accept; the unit must have latched them.
      bus.in_valid = 1'b0;
      bus.a_in     = 4'($urandom);
      bus.b_in     = 4'($urandom);
      bus.opcode   = 4'($urandom);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: compares each presented result and drives out_ready.
  logic       in_hold = 1'b0;
  logic       prev_hs = 1'b0;
  logic [3:0] held = 4'd0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      in_hold = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (prev_hs) check("out_valid_drop", 32'(bus.out_valid), 32'd0);
      if (bus.out_valid && !prev_hs) begin
        if (!in_hold) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("result", 32'(bus.shift_out), 32'(e.res));
            check("latency", 32'(cyc - e.acc), 32'(e.lat));
          end
          held    = bus.shift_out;
          in_hold = 1'b1;
        end else begin
          check("hold_stable", 32'(bus.shift_out), 32'(held));
        end
        check("done_in_ready", 32'(bus.in_ready), 32'd0);
        check("done_busy", 32'(bus.busy), 32'd1);
      end
      case (rdy_mode)
        0:       bus.out_ready = 1'($urandom_range(0, 1));
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'b0;
      endcase
      prev_hs = bus.out_valid && bus.out_ready;
      if (prev_hs) in_hold = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int acc1;
    int acc2;
    int n;
    logic seen_ov;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rop;

    bus.in_valid  = 1'b0;
    bus.a_in      = 4'd0;
    bus.b_in      = 4'd0;
    bus.opcode    = 4'd0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_shift_out", 32'(bus.shift_out), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;

    // Directed vectors
    rdy_mode = 1;
    do_job(4'b0010, 4'b1001, OP_SHL, acc1);
    do_job(4'b0010, 4'b1001, OP_SAR, acc1);
    do_job(4'b0010, 4'b1001, OP_SHR, acc1);
    do_job(4'b0001, 4'b1001, OP_ROL, acc1);
    do_job(4'b0001, 4'b1001, OP_ROR, acc1);
    for (int op = 0; op < 6; op++) do_job(4'b0000, 4'b1001, 4'(op), acc1);
    do_job(4'b0011, 4'b1010, 4'b1111, acc1);
    drain();

    // Consumer stalls: result held, new offers refused.
    rdy_mode = 2;
    do_job(4'b0011, 4'b0101, OP_ROL, acc1);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("hold_reached_done", 32'(bus.out_valid), 32'd1);
    repeat (5) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a_in     = 4'($urandom);
      bus.b_in     = 4'($urandom);
      bus.opcode   = 4'($urandom_range(0, 5));
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rdy_mode = 1;
    drain();

    // Reset in the middle of a shift discards the job.
    do_job(4'b0011, 4'b1011, OP_SAR, acc1);
    reset = 1'b1;
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    seen_ov = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) seen_ov = 1'b1;
    end
    check("midrst_no_out_valid", 32'(seen_ov), 32'd0);

    // Back-to-back: handshake edge, then the following edge accepts the next job.
    rdy_mode = 1;
    do_job(4'b0010, 4'b0110, OP_SHL, acc1);
    do_job(4'b0001, 4'b1101, OP_ROR, acc2);
    check("b2b_accept_gap", 32'(acc2 - acc1), 32'(ref_lat(4'b0010, OP_SHL) + 2));
    drain();

    // Randomized jobs with a randomly stalling consumer.
    rdy_mode = 0;
    repeat (150) begin
      ra  = 4'($urandom);
      rb  = 4'($urandom);
      rop = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(0, 5));
      do_job(ra, rb, rop, acc1);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
